// File: rtl/adc_line_align.sv
// Training controller for one deserialized ADC line. It scans the IODELAY taps for the widest
// stable eye, parks the delay at the eye centre, then bitslips until DOUT matches PATTERN.
module adc_line_align #(
  parameter int MAXTAP = 63,
  parameter int SETTLE = 8,
  parameter int NCHK   = 16,
  parameter int MINEYE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] PATTERN,
  input  logic [5:0] DOUT,
  output logic       SRST,
  output logic       DRST,
  output logic       DINC,
  output logic       BS,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] TAP,
  output logic [2:0] SLIPS
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RESET   = 4'd1;
  localparam logic [3:0] S_WAIT    = 4'd2;
  localparam logic [3:0] S_CHECK   = 4'd3;
  localparam logic [3:0] S_NEXT    = 4'd4;
  localparam logic [3:0] S_EVAL    = 4'd5;
  localparam logic [3:0] S_REWIND  = 4'd6;
  localparam logic [3:0] S_STEP    = 4'd7;
  localparam logic [3:0] S_SLIPCHK = 4'd8;
  localparam logic [3:0] S_SLIP    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;
  localparam logic [3:0] S_FAIL    = 4'd11;

  localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
  localparam logic [15:0] NCHK_M1   = 16'(NCHK - 1);
  localparam logic [7:0]  MAXTAP_C  = 8'(MAXTAP);
  localparam logic [8:0]  MINEYE_C  = 9'(MINEYE);

  logic [3:0]  state_q, state_d, ret_q, ret_d;
  logic [15:0] cnt_q, cnt_d;
  logic        good_q, good_d;
  logic [7:0]  tap_q, tap_d, rstart_q, rstart_d, bstart_q, bstart_d, target_q, target_d;
  logic [8:0]  run_q, run_d, best_q, best_d;
  logic [2:0]  slips_q, slips_d;
  logic [5:0]  cap_q;
  logic        tap_good;
  logic [8:0]  run_inc;
  logic [7:0]  run_start;

  // The tap verdict is only meaningful on the last compare cycle of CHECK.
  assign tap_good  = good_q & (DOUT == cap_q);
  assign run_inc   = run_q + 9'd1;
  assign run_start = (run_q == 9'd0) ? tap_q : rstart_q;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    tap_d    = tap_q;
    rstart_d = rstart_q;
    bstart_d = bstart_q;
    target_d = target_q;
    run_d    = run_q;
    best_d   = best_q;
    slips_d  = slips_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          state_d  = S_RESET;
          cnt_d    = 16'd0;
          tap_d    = 8'd0;
          slips_d  = 3'd0;
          run_d    = 9'd0;
          best_d   = 9'd0;
          rstart_d = 8'd0;
          bstart_d = 8'd0;
          target_d = 8'd0;
        end
      end
      S_RESET: begin
        if (cnt_q == 16'd3) begin
          state_d = S_WAIT;
          ret_d   = S_CHECK;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == SETTLE_M1) begin
          state_d = ret_q;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CHECK: begin
        if (cnt_q == 16'd0) begin
          good_d = 1'b1;
          cnt_d  = 16'd1;
        end else if (cnt_q == NCHK_M1) begin
          cnt_d = 16'd0;
          if (tap_good) begin
            rstart_d = run_start;
            run_d    = run_inc;
            if (run_inc > best_q) begin
              best_d   = run_inc;
              bstart_d = run_start;
            end
          end else begin
            run_d = 9'd0;
          end
          if (tap_q == MAXTAP_C) begin
            state_d = S_EVAL;
          end else begin
            state_d = S_NEXT;
            ret_d   = S_CHECK;
            tap_d   = tap_q + 8'd1;
          end
        end else begin
          good_d = tap_good;
          cnt_d  = cnt_q + 16'd1;
        end
      end
      S_NEXT, S_SLIP: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_EVAL: begin
        if (best_q < MINEYE_C) begin
          state_d = S_FAIL;
        end else begin
          target_d = bstart_q + best_q[8:1];
          state_d  = S_REWIND;
          tap_d    = 8'd0;
        end
      end
      S_REWIND: begin
        state_d = S_WAIT;
        ret_d   = S_STEP;
        cnt_d   = 16'd0;
      end
      S_STEP: begin
        if (tap_q == target_q) begin
          state_d = S_WAIT;
          ret_d   = S_SLIPCHK;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_NEXT;
          ret_d   = S_STEP;
          tap_d   = tap_q + 8'd1;
        end
      end
      S_SLIPCHK: begin
        if (DOUT != PATTERN) begin
          cnt_d = 16'd0;
          if (slips_q == 3'd6) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_SLIP;
            ret_d   = S_SLIPCHK;
            slips_d = slips_q + 3'd1;
          end
        end else if (cnt_q == NCHK_M1) begin
          state_d = S_DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // TAP and SLIPS advance on entry to the pulse states, so they move with their pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      cnt_q    <= 16'd0;
      good_q   <= 1'b0;
      tap_q    <= 8'd0;
      rstart_q <= 8'd0;
      bstart_q <= 8'd0;
      target_q <= 8'd0;
      run_q    <= 9'd0;
      best_q   <= 9'd0;
      slips_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      tap_q    <= tap_d;
      rstart_q <= rstart_d;
      bstart_q <= bstart_d;
      target_q <= target_d;
      run_q    <= run_d;
      best_q   <= best_d;
      slips_q  <= slips_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_CHECK && cnt_q == 16'd0) cap_q <= DOUT;
  end

  assign SRST  = (state_q == S_RESET);
  assign DRST  = (state_q == S_RESET) || (state_q == S_REWIND);
  assign DINC  = (state_q == S_NEXT);
  assign BS    = (state_q == S_SLIP);
  assign BUSY  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign DONE  = (state_q == S_DONE);
  assign ERR   = (state_q == S_FAIL);
  assign TAP   = tap_q;
  assign SLIPS = slips_q;

endmodule

// File: tb/tb_adc_line_align.sv
// Bench for adc_line_align: a behavioural receiver (tap-dependent eye, bitslip-dependent word)
// drives DOUT while outcomes are predicted from the eye map with plain run enumeration.
module tb_adc_line_align;

  localparam int MAXTAP = 63;
  localparam int SETTLE = 8;
  localparam int NCHK   = 16;
  localparam int MINEYE = 4;
  localparam int SCAN   = 4 + SETTLE + (MAXTAP + 1) * NCHK + MAXTAP * (1 + SETTLE);

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [5:0] PATTERN = 6'd0;
  logic [5:0] DOUT = 6'd0;
  logic       SRST, DRST, DINC, BS, BUSY, DONE, ERR;
  logic [7:0] TAP;
  logic [2:0] SLIPS;

  adc_line_align #(.MAXTAP(MAXTAP), .SETTLE(SETTLE), .NCHK(NCHK), .MINEYE(MINEYE)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN), .DOUT(DOUT),
    .SRST(SRST), .DRST(DRST), .DINC(DINC), .BS(BS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .TAP(TAP), .SLIPS(SLIPS)
  );

  always #5 CLK = ~CLK;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  bit  good [0:255];
  int  need_q = 0;
  logic [5:0] alt = 6'd0;

  // receiver / monitor state
  int  rx_tap = 0, rx_slip = 0, bs_cnt = 0, dinc_cnt = 0;
  int  mtap = 0, tapviol = 0, viol = 0, quiet = 1000;
  bit  tog = 1'b0;

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Pulses seen this cycle take effect in the receiver; DOUT then reflects the new state.
  initial forever begin
    @(negedge CLK);
    if (RST || DRST) mtap = 0;
    else if (DINC) mtap++;
    if (int'(TAP) != mtap) tapviol++;
    if (DINC || BS) begin
      if (quiet < SETTLE || (DINC && BS)) viol++;
      quiet = 0;
    end else if (quiet < 1000) begin
      quiet++;
    end
    if (SRST) rx_slip = 0;
    if (DRST) begin
      rx_tap = 0;
      dinc_cnt = 0;
    end else if (DINC) begin
      rx_tap++;
      dinc_cnt++;
    end
    if (BS) begin
      rx_slip++;
      bs_cnt++;
    end
    if (good[rx_tap % 256]) DOUT = (rx_slip == need_q) ? PATTERN : (PATTERN ^ 6'h2A);
    else begin
      tog = !tog;
      DOUT = tog ? alt : ~alt;
    end
  end

  function automatic void ref_eye(output int best, output int bstart);
    int t, s;
    best = 0;
    bstart = 0;
    t = 0;
    while (t <= MAXTAP) begin
      if (good[t]) begin
        s = t;
        while (t <= MAXTAP && good[t]) t++;
        if (t - s > best) begin
          best = t - s;
          bstart = s;
        end
      end else begin
        t++;
      end
    end
  endfunction

  task automatic setup_case(input int lo1, input int hi1, input int lo2, input int hi2,
                            input int need);
    for (int t = 0; t < 256; t++)
      good[t] = (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
    need_q = need;
    PATTERN = 6'($urandom);
    alt = 6'($urandom);
  endtask

  task automatic run_case(input string name, input int lo1, input int hi1, input int lo2,
                          input int hi2, input int need, input bit poke);
    int best, bstart, target, exp_tap, exp_slips, exp_dinc, t0, t_evt, bs0;
    bit exp_done, eye_ok, got_evt, fin;
    setup_case(lo1, hi1, lo2, hi2, need);
    ref_eye(best, bstart);
    eye_ok = (best >= MINEYE);
    target = bstart + best / 2;
    if (!eye_ok) begin
      exp_done = 0; exp_tap = MAXTAP; exp_slips = 0; exp_dinc = MAXTAP;
    end else if (need <= 5) begin
      exp_done = 1; exp_tap = target; exp_slips = need; exp_dinc = target;
    end else begin
      exp_done = 0; exp_tap = target; exp_slips = 6; exp_dinc = target;
    end
    bs0 = bs_cnt;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check_val({name, ".busy_rise"}, int'(BUSY), 1);
    check_val({name, ".srst"}, int'({SRST, DONE, ERR}), 4);
    t0 = cyc;
    t_evt = 0;
    got_evt = 0;
    fin = 0;
    for (int i = 0; i < 12000 && !fin; i++) begin
      @(negedge CLK);
      START = (poke && cyc == t0 + 100);
      if (!got_evt && ((DRST && !SRST) || ERR)) begin
        got_evt = 1;
        t_evt = cyc;
      end
      if (DONE || ERR) begin
        fin = 1;
        check_val({name, ".busy_fall"}, int'(BUSY), 0);
      end
    end
    START = 1'b0;
    check_val({name, ".finished"}, int'(fin), 1);
    check_val({name, ".scan_len"}, t_evt - t0, SCAN + 1);
    check_val({name, ".done"}, int'(DONE), int'(exp_done));
    check_val({name, ".err"}, int'(ERR), int'(!exp_done));
    check_val({name, ".tap"}, int'(TAP), exp_tap);
    check_val({name, ".slips"}, int'(SLIPS), exp_slips);
    check_val({name, ".bs_pulses"}, bs_cnt - bs0, exp_slips);
    check_val({name, ".dinc_after_drst"}, dinc_cnt, exp_dinc);
    check_val({name, ".pulse_spacing"}, viol, 0);
    check_val({name, ".tap_track"}, tapviol, 0);
    repeat (5) @(negedge CLK);
    check_val({name, ".hold"}, int'({DONE, ERR, BUSY, TAP}),
              int'({exp_done, !exp_done, 1'b0, 8'(exp_tap)}));
  endtask

  initial begin
    int lo, len;
    repeat (3) @(posedge CLK);
    #1;
    check_val("reset.outputs", int'({SRST, DRST, DINC, BS, BUSY, DONE, ERR, TAP, SLIPS}), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("idle.outputs", int'({SRST, DRST, DINC, BS, BUSY, DONE, ERR, TAP, SLIPS}), 0);

    run_case("centre", 20, 35, 1, 0, 3, 1'b1);
    run_case("no_eye", 1, 0, 1, 0, 0, 1'b0);
    run_case("small_eye", 10, 12, 1, 0, 0, 1'b0);
    run_case("tie", 5, 9, 40, 44, 0, 1'b0);
    run_case("edge_eye", 58, 63, 1, 0, 2, 1'b0);
    run_case("no_match", 20, 35, 1, 0, 7, 1'b0);

    // Abort mid-scan with an asynchronous reset, then retrain from scratch.
    setup_case(20, 35, 1, 0, 3);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 5000 && TAP != 8'd30; i++) @(negedge CLK);
    check_val("midrst.reach_tap30", int'(TAP), 30);
    #2;
    RST = 1'b1;
    #1;
    check_val("midrst.outputs", int'({SRST, DRST, DINC, BS, BUSY, DONE, ERR, TAP, SLIPS}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_case("rerun", 20, 35, 1, 0, 3, 1'b1);

    for (int k = 0; k < 4; k++) begin
      lo = $urandom_range(0, 58);
      len = $urandom_range(4, 20);
      run_case($sformatf("rand%0d", k), lo, (lo + len - 1 > MAXTAP) ? MAXTAP : lo + len - 1,
               1, 0, int'($urandom_range(0, 6)) == 6 ? 7 : int'($urandom_range(0, 5)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
